// File: rtl/agc_seq_pkg.sv
// Shared types and widths for the AGC closed-loop sequencer.
// Pure declarations, no logic.
// No flow control.
package agc_seq_pkg;

    localparam int SCALE_W  = 17;
    localparam int OFFSET_W = 16;
    localparam int SQ_W     = 24;
    localparam int CMP_W    = 21;

    // Q8.8 offset saturation limits
    localparam int OFS_MAX = 32767;
    localparam int OFS_MIN = -32768;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_APPLY,
        S_TICK,
        S_INTEG,
        S_SETTLE,
        S_EVAL
    } seq_state_t;

endpackage

// File: rtl/agc_step_sat.sv
// Bang-bang control law: next scale/offset with saturation plus unchanged flags.
// Purely combinational, zero latency.
// No flow control; the result is consumed by the sequencer in its evaluation cycle.
module agc_step_sat
    import agc_seq_pkg::*;
#(
    parameter logic [SCALE_W-1:0] SCALE_MIN = 17'h00100,
    parameter logic [SCALE_W-1:0] SCALE_MAX = 17'h1FFFF
) (
    input  logic [SCALE_W-1:0]         scale_cur,
    input  logic signed [OFFSET_W-1:0] offset_cur,
    input  logic [SQ_W-1:0]            sq_accum,
    input  logic [SQ_W-1:0]            sq_target_lo,
    input  logic [SQ_W-1:0]            sq_target_hi,
    input  logic [7:0]                 scale_step,
    input  logic [CMP_W-1:0]           gt_accum,
    input  logic [CMP_W-1:0]           lt_accum,
    input  logic [CMP_W-1:0]           ofs_thresh,
    input  logic [7:0]                 ofs_step,
    output logic [SCALE_W-1:0]         scale_nxt,
    output logic [OFFSET_W-1:0]        offset_nxt,
    output logic                       scale_same,
    output logic                       offset_same
);

    localparam logic signed [OFFSET_W+1:0] OFS_HI_X = (OFFSET_W+2)'(OFS_MAX);
    localparam logic signed [OFFSET_W+1:0] OFS_LO_X = (OFFSET_W+2)'(OFS_MIN);

    logic                          win_empty;
    logic                          scale_up_req;
    logic                          scale_dn_req;
    logic [SCALE_W:0]              scale_up;
    logic [SCALE_W:0]              scale_dn;
    logic signed [CMP_W:0]         diff;
    logic signed [CMP_W:0]         thr;
    logic signed [OFFSET_W+1:0]    ofs_ext;
    logic signed [OFFSET_W+1:0]    ofs_up;
    logic signed [OFFSET_W+1:0]    ofs_dn;
    logic signed [OFFSET_W+1:0]    ofs_sel;

    // An inverted window can never be satisfied, so it always pushes scale up
    assign win_empty    = sq_target_lo > sq_target_hi;
    assign scale_up_req = win_empty || (sq_accum < sq_target_lo);
    assign scale_dn_req = !win_empty && (sq_accum > sq_target_hi);

    assign scale_up = {1'b0, scale_cur} + {{(SCALE_W-7){1'b0}}, scale_step};
    assign scale_dn = {1'b0, scale_cur} - {{(SCALE_W-7){1'b0}}, scale_step};

    assign diff    = $signed({1'b0, gt_accum}) - $signed({1'b0, lt_accum});
    assign thr     = $signed({1'b0, ofs_thresh});
    assign ofs_ext = {{2{offset_cur[OFFSET_W-1]}}, offset_cur};
    assign ofs_up  = ofs_ext + $signed({{(OFFSET_W-6){1'b0}}, ofs_step});
    assign ofs_dn  = ofs_ext - $signed({{(OFFSET_W-6){1'b0}}, ofs_step});

    always_comb begin
        scale_nxt = scale_cur;
        if (scale_up_req) begin
            scale_nxt = (scale_up > {1'b0, SCALE_MAX}) ? SCALE_MAX : scale_up[SCALE_W-1:0];
        end else if (scale_dn_req) begin
            // Borrow out of the subtraction also means we went below the floor
            scale_nxt = (scale_dn[SCALE_W] || (scale_dn[SCALE_W-1:0] < SCALE_MIN))
                        ? SCALE_MIN : scale_dn[SCALE_W-1:0];
        end
    end

    always_comb begin
        ofs_sel = ofs_ext;
        if (diff > thr) begin
            ofs_sel = (ofs_dn < OFS_LO_X) ? OFS_LO_X : ofs_dn;
        end else if (diff < -thr) begin
            ofs_sel = (ofs_up > OFS_HI_X) ? OFS_HI_X : ofs_up;
        end
    end

    assign offset_nxt  = ofs_sel[OFFSET_W-1:0];
    assign scale_same  = (scale_nxt == scale_cur);
    assign offset_same = (offset_nxt == offset_cur);

endmodule

// File: rtl/agc_loop_sequencer.sv
// Closed-loop AGC controller: reset, integrate, settle, evaluate, then load/apply scale and offset.
// One iteration takes INTEG_CLOCKS + SETTLE_CLOCKS + 4 cycles; all outputs decode from registered state.
// No backpressure; dropping enable_i aborts the current iteration and parks in IDLE.
module agc_loop_sequencer
    import agc_seq_pkg::*;
#(
    parameter int                 INTEG_CLOCKS  = 131072,
    parameter int                 SETTLE_CLOCKS = 6,
    parameter logic [SCALE_W-1:0] SCALE_MIN     = 17'h00100,
    parameter logic [SCALE_W-1:0] SCALE_MAX     = 17'h1FFFF,
    parameter int                 LOCK_COUNT    = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable_i,
    input  logic [SCALE_W-1:0]  scale_init_i,
    input  logic [OFFSET_W-1:0] offset_init_i,
    input  logic [SQ_W-1:0]     sq_target_lo_i,
    input  logic [SQ_W-1:0]     sq_target_hi_i,
    input  logic [7:0]          scale_step_i,
    input  logic [CMP_W-1:0]    ofs_thresh_i,
    input  logic [7:0]          ofs_step_i,
    input  logic [SQ_W-1:0]     sq_accum_i,
    input  logic [CMP_W-1:0]    gt_accum_i,
    input  logic [CMP_W-1:0]    lt_accum_i,
    output logic                agc_rst_o,
    output logic                agc_tick_o,
    output logic                agc_ce_o,
    output logic [SCALE_W-1:0]  agc_scale_o,
    output logic [OFFSET_W-1:0] agc_offset_o,
    output logic                agc_scale_ce_o,
    output logic                agc_offset_ce_o,
    output logic                agc_apply_o,
    output logic                iter_done_o,
    output logic [15:0]         iter_count_o,
    output logic                locked_o
);

    localparam int               CNT_W       = $clog2(INTEG_CLOCKS) + 1;
    localparam logic [CNT_W-1:0] INTEG_LAST  = CNT_W'(INTEG_CLOCKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CLOCKS - 1);
    localparam int               STB_W       = $clog2(LOCK_COUNT + 1);
    localparam logic [STB_W-1:0] LOCK_VAL    = STB_W'(LOCK_COUNT);

    seq_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [STB_W-1:0]           stable_q;
    logic                       init_q;
    logic [SCALE_W-1:0]         scale_q;
    logic signed [OFFSET_W-1:0] offset_q;
    logic [15:0]                iter_cnt_q;
    logic                       run_abort;
    logic [SCALE_W-1:0]         scale_nxt;
    logic [OFFSET_W-1:0]        offset_nxt;
    logic                       scale_same;
    logic                       offset_same;

    assign run_abort = !enable_i &&
                       (state_q inside {S_TICK, S_INTEG, S_SETTLE, S_EVAL});

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable_i) state_d = S_START;
            S_START:  state_d = S_LOAD;
            S_LOAD:   state_d = S_APPLY;
            S_APPLY:  state_d = enable_i ? S_TICK : S_IDLE;
            S_TICK:   state_d = S_INTEG;
            S_INTEG:  if (cnt_q == INTEG_LAST) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_EVAL;
            S_EVAL:   state_d = S_LOAD;
            default:  state_d = S_IDLE;
        endcase
        if (run_abort) state_d = S_IDLE;
    end

    // One counter serves both phases; it restarts at the INTEG->SETTLE boundary
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (state_q == S_TICK) begin
            cnt_q <= '0;
        end else if (state_q == S_INTEG) begin
            cnt_q <= (cnt_q == INTEG_LAST) ? '0 : cnt_q + CNT_W'(1);
        end else if (state_q == S_SETTLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    agc_step_sat #(
        .SCALE_MIN (SCALE_MIN),
        .SCALE_MAX (SCALE_MAX)
    ) u_step_sat (
        .scale_cur    (scale_q),
        .offset_cur   (offset_q),
        .sq_accum     (sq_accum_i),
        .sq_target_lo (sq_target_lo_i),
        .sq_target_hi (sq_target_hi_i),
        .scale_step   (scale_step_i),
        .gt_accum     (gt_accum_i),
        .lt_accum     (lt_accum_i),
        .ofs_thresh   (ofs_thresh_i),
        .ofs_step     (ofs_step_i),
        .scale_nxt    (scale_nxt),
        .offset_nxt   (offset_nxt),
        .scale_same   (scale_same),
        .offset_same  (offset_same)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            scale_q    <= '0;
            offset_q   <= '0;
            init_q     <= 1'b0;
            iter_cnt_q <= '0;
            stable_q   <= '0;
        end else if (run_abort) begin
            stable_q <= '0;
        end else begin
            case (state_q)
                S_START: begin
                    scale_q    <= scale_init_i;
                    offset_q   <= offset_init_i;
                    init_q     <= 1'b1;
                    iter_cnt_q <= '0;
                    stable_q   <= '0;
                end
                S_APPLY: begin
                    // The apply that follows START only pushes initial values
                    if (!init_q) iter_cnt_q <= iter_cnt_q + 16'd1;
                    init_q <= 1'b0;
                end
                S_EVAL: begin
                    scale_q  <= scale_nxt;
                    offset_q <= offset_nxt;
                    if (scale_same && offset_same)
                        stable_q <= (stable_q == LOCK_VAL) ? stable_q : stable_q + STB_W'(1);
                    else
                        stable_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign agc_rst_o       = (state_q == S_START);
    assign agc_tick_o      = (state_q == S_TICK);
    assign agc_ce_o        = (state_q == S_INTEG);
    assign agc_scale_ce_o  = (state_q == S_LOAD);
    assign agc_offset_ce_o = (state_q == S_LOAD);
    assign agc_apply_o     = (state_q == S_APPLY);
    assign iter_done_o     = (state_q == S_APPLY) && !init_q;
    assign agc_scale_o     = scale_q;
    assign agc_offset_o    = offset_q;
    assign iter_count_o    = iter_cnt_q;
    assign locked_o        = (stable_q == LOCK_VAL);

endmodule

// File: tb/tb_agc_loop_sequencer.sv
// Directed bench for agc_loop_sequencer with a short integration window.
module tb_agc_loop_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable_i;
    logic [16:0] scale_init_i;
    logic [15:0] offset_init_i;
    logic [23:0] sq_target_lo_i, sq_target_hi_i, sq_accum_i;
    logic [7:0]  scale_step_i, ofs_step_i;
    logic [20:0] ofs_thresh_i, gt_accum_i, lt_accum_i;
    logic        agc_rst_o, agc_tick_o, agc_ce_o;
    logic [16:0] agc_scale_o;
    logic [15:0] agc_offset_o;
    logic        agc_scale_ce_o, agc_offset_ce_o, agc_apply_o, iter_done_o;
    logic [15:0] iter_count_o;
    logic        locked_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    agc_loop_sequencer #(
        .INTEG_CLOCKS  (16),
        .SETTLE_CLOCKS (6),
        .SCALE_MIN     (17'h00100),
        .SCALE_MAX     (17'h1FFFF),
        .LOCK_COUNT    (4)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .enable_i        (enable_i),
        .scale_init_i    (scale_init_i),
        .offset_init_i   (offset_init_i),
        .sq_target_lo_i  (sq_target_lo_i),
        .sq_target_hi_i  (sq_target_hi_i),
        .scale_step_i    (scale_step_i),
        .ofs_thresh_i    (ofs_thresh_i),
        .ofs_step_i      (ofs_step_i),
        .sq_accum_i      (sq_accum_i),
        .gt_accum_i      (gt_accum_i),
        .lt_accum_i      (lt_accum_i),
        .agc_rst_o       (agc_rst_o),
        .agc_tick_o      (agc_tick_o),
        .agc_ce_o        (agc_ce_o),
        .agc_scale_o     (agc_scale_o),
        .agc_offset_o    (agc_offset_o),
        .agc_scale_ce_o  (agc_scale_ce_o),
        .agc_offset_ce_o (agc_offset_ce_o),
        .agc_apply_o     (agc_apply_o),
        .iter_done_o     (iter_done_o),
        .iter_count_o    (iter_count_o),
        .locked_o        (locked_o)
    );

    function automatic logic [62:0] all_outs();
        return {agc_rst_o, agc_tick_o, agc_ce_o, agc_scale_o, agc_offset_o, agc_scale_ce_o,
                agc_offset_ce_o, agc_apply_o, iter_done_o, iter_count_o, locked_o, 9'd0};
    endfunction

    // Default config: sq inside window, gt == lt, initial scale 0x08000 / offset 0
    task automatic do_reset();
        aresetn = 1'b0;  enable_i = 1'b0;
        scale_init_i = 17'h08000;  offset_init_i = 16'h0000;
        sq_target_lo_i = 24'h100000;  sq_target_hi_i = 24'h180000;  sq_accum_i = 24'h140000;
        scale_step_i = 8'h40;  ofs_step_i = 8'd8;  ofs_thresh_i = 21'd50;
        gt_accum_i = 21'd0;  lt_accum_i = 21'd0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic wait_iter(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge aclk);
            if (agc_apply_o && iter_done_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge aclk);
            if (agc_tick_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;  enable_i = 1'b0;
        @(negedge aclk);
        n_assert++;
        if (all_outs() !== 63'd0) begin n_fail++; $display("FAIL reset_outs: got %h exp 0", all_outs()); end
        do_reset();
        repeat (3) @(negedge aclk);
        n_assert++;
        if (all_outs() !== 63'd0) begin n_fail++; $display("FAIL idle_quiet: got %h exp 0", all_outs()); end
    endtask

    task automatic test_first_iteration();
        int n;
        do_reset();
        enable_i = 1'b1;
        @(negedge aclk);
        n_assert++;
        if ({agc_rst_o, agc_scale_ce_o} !== 2'b10) begin n_fail++; $display("FAIL start_rst: got %b exp 10", {agc_rst_o, agc_scale_ce_o}); end
        @(negedge aclk);
        n_assert++;
        if ({agc_scale_ce_o, agc_offset_ce_o, agc_scale_o} !== {2'b11, 17'h08000}) begin
            n_fail++; $display("FAIL init_load: got ce=%b%b scale=%h exp 11/08000", agc_scale_ce_o, agc_offset_ce_o, agc_scale_o);
        end
        @(negedge aclk);
        n_assert++;
        if ({agc_apply_o, iter_done_o} !== 2'b10) begin n_fail++; $display("FAIL init_apply: got %b exp 10", {agc_apply_o, iter_done_o}); end
        @(negedge aclk);
        n_assert++;
        if ({agc_tick_o, agc_ce_o} !== 2'b10) begin n_fail++; $display("FAIL tick: got %b exp 10", {agc_tick_o, agc_ce_o}); end
        n = 0;
        repeat (16) begin @(negedge aclk); if (agc_ce_o) n++; end
        n_assert++;
        if (n != 16) begin n_fail++; $display("FAIL integ_len: got %0d exp 16", n); end
        n = 0;
        repeat (7) begin @(negedge aclk); if (agc_ce_o || agc_scale_ce_o || agc_apply_o || agc_tick_o) n++; end
        n_assert++;
        if (n != 0) begin n_fail++; $display("FAIL settle_quiet: got %0d busy cycles exp 0", n); end
        @(negedge aclk);
        n_assert++;
        if (agc_scale_ce_o !== 1'b1) begin n_fail++; $display("FAIL iter_load: got %b exp 1", agc_scale_ce_o); end
        @(negedge aclk);
        n_assert++;
        if ({agc_apply_o, iter_done_o, iter_count_o} !== {2'b11, 16'd0}) begin
            n_fail++; $display("FAIL iter_apply: got %b%b cnt=%0d exp 11 cnt=0", agc_apply_o, iter_done_o, iter_count_o);
        end
        @(negedge aclk);
        n_assert++;
        if ({agc_tick_o, iter_count_o} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL iter_count: got tick=%b cnt=%0d exp 1/1", agc_tick_o, iter_count_o); end
        enable_i = 1'b0;
    endtask

    task automatic test_scale_step();
        bit ok;
        do_reset();
        sq_accum_i = 24'h200000;
        enable_i = 1'b1;
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_scale_o !== 17'h07FC0) begin n_fail++; $display("FAIL scale_dn1: got %h ok=%b exp 07fc0", agc_scale_o, ok); end
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_scale_o !== 17'h07F80) begin n_fail++; $display("FAIL scale_dn2: got %h ok=%b exp 07f80", agc_scale_o, ok); end
        n_assert++;
        if (agc_offset_o !== 16'h0000) begin n_fail++; $display("FAIL ofs_hold: got %h exp 0000", agc_offset_o); end
        enable_i = 1'b0;
    endtask

    task automatic test_scale_clamp();
        bit ok;
        do_reset();
        sq_accum_i = 24'h200000;  scale_init_i = 17'h00110;
        enable_i = 1'b1;
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_scale_o !== 17'h00100) begin n_fail++; $display("FAIL clamp1: got %h ok=%b exp 00100", agc_scale_o, ok); end
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_scale_o !== 17'h00100) begin n_fail++; $display("FAIL clamp2: got %h ok=%b exp 00100", agc_scale_o, ok); end
        enable_i = 1'b0;
    endtask

    task automatic test_empty_window();
        bit ok;
        do_reset();
        sq_target_lo_i = 24'h180000;  sq_target_hi_i = 24'h100000;
        enable_i = 1'b1;
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_scale_o !== 17'h08040) begin n_fail++; $display("FAIL empty_win: got %h ok=%b exp 08040", agc_scale_o, ok); end
        enable_i = 1'b0;
    endtask

    task automatic test_offset();
        bit ok;
        do_reset();
        gt_accum_i = 21'd1000;  lt_accum_i = 21'd100;
        enable_i = 1'b1;
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_offset_o !== 16'hFFF8) begin n_fail++; $display("FAIL ofs_dn1: got %h ok=%b exp fff8", agc_offset_o, ok); end
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_offset_o !== 16'hFFF0) begin n_fail++; $display("FAIL ofs_dn2: got %h ok=%b exp fff0", agc_offset_o, ok); end
        enable_i = 1'b0;
        do_reset();
        gt_accum_i = 21'd100;  lt_accum_i = 21'd1000;  offset_init_i = 16'h7FFC;
        enable_i = 1'b1;
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_offset_o !== 16'h7FFF) begin n_fail++; $display("FAIL ofs_sat1: got %h ok=%b exp 7fff", agc_offset_o, ok); end
        wait_iter(ok);
        n_assert++;
        if (!ok || agc_offset_o !== 16'h7FFF) begin n_fail++; $display("FAIL ofs_sat2: got %h ok=%b exp 7fff", agc_offset_o, ok); end
        enable_i = 1'b0;
    endtask

    task automatic test_lock();
        bit ok;
        do_reset();
        gt_accum_i = 21'd110;  lt_accum_i = 21'd100;
        enable_i = 1'b1;
        repeat (3) wait_iter(ok);
        n_assert++;
        if (!ok || locked_o !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b ok=%b exp 0", locked_o, ok); end
        wait_iter(ok);
        n_assert++;
        if (!ok || locked_o !== 1'b1 || iter_count_o !== 16'd3) begin
            n_fail++; $display("FAIL lock_rise: got %b cnt=%0d ok=%b exp 1 cnt=3", locked_o, iter_count_o, ok);
        end
        sq_accum_i = 24'h200000;
        wait_iter(ok);
        n_assert++;
        if (!ok || locked_o !== 1'b0 || agc_scale_o !== 17'h07FC0) begin
            n_fail++; $display("FAIL lock_clear: got %b scale=%h ok=%b exp 0/07fc0", locked_o, agc_scale_o, ok);
        end
        enable_i = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit ok;
        int n;
        do_reset();
        enable_i = 1'b1;
        wait_tick(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL drop_tick: got timeout exp tick"); end
        repeat (5) @(negedge aclk);
        n_assert++;
        if (agc_ce_o !== 1'b1) begin n_fail++; $display("FAIL drop_ce5: got %b exp 1", agc_ce_o); end
        enable_i = 1'b0;
        @(negedge aclk);
        n_assert++;
        if (agc_ce_o !== 1'b0) begin n_fail++; $display("FAIL drop_ce_off: got %b exp 0", agc_ce_o); end
        n = 0;
        repeat (40) begin
            @(negedge aclk);
            if (agc_rst_o || agc_tick_o || agc_ce_o || agc_scale_ce_o || agc_offset_ce_o || agc_apply_o || iter_done_o) n++;
        end
        n_assert++;
        if (n != 0 || agc_scale_o !== 17'h08000 || locked_o !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle: got pulses=%0d scale=%h lock=%b exp 0/08000/0", n, agc_scale_o, locked_o);
        end
        scale_init_i = 17'h0A000;
        enable_i = 1'b1;
        @(negedge aclk);
        n_assert++;
        if (agc_rst_o !== 1'b1) begin n_fail++; $display("FAIL reen_rst: got %b exp 1", agc_rst_o); end
        @(negedge aclk);
        n_assert++;
        if ({agc_scale_ce_o, agc_scale_o} !== {1'b1, 17'h0A000}) begin n_fail++; $display("FAIL reen_load: got %b/%h exp 1/0a000", agc_scale_ce_o, agc_scale_o); end
        enable_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        sq_accum_i = 24'h200000;
        enable_i = 1'b1;
        wait_iter(ok);
        wait_tick(ok);
        repeat (18) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        n_assert++;
        if (!ok || all_outs() !== 63'd0) begin n_fail++; $display("FAIL async_rst: got %h ok=%b exp 0", all_outs(), ok); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_assert++;
        if (agc_rst_o !== 1'b1) begin n_fail++; $display("FAIL rel_rst: got %b exp 1", agc_rst_o); end
        @(negedge aclk);
        n_assert++;
        if (agc_scale_o !== 17'h08000) begin n_fail++; $display("FAIL rel_load: got %h exp 08000", agc_scale_o); end
        @(negedge aclk);
        n_assert++;
        if ({agc_apply_o, iter_done_o, iter_count_o} !== {2'b10, 16'd0}) begin
            n_fail++; $display("FAIL rel_apply: got %b%b cnt=%0d exp 10 cnt=0", agc_apply_o, iter_done_o, iter_count_o);
        end
        enable_i = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;  enable_i = 1'b0;
        scale_init_i = '0;  offset_init_i = '0;
        sq_target_lo_i = '0;  sq_target_hi_i = '0;  sq_accum_i = '0;
        scale_step_i = '0;  ofs_step_i = '0;  ofs_thresh_i = '0;
        gt_accum_i = '0;  lt_accum_i = '0;
        test_reset();
        test_first_iteration();
        test_scale_step();
        test_scale_clamp();
        test_empty_window();
        test_offset();
        test_lock();
        test_enable_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/agc_loop_sequencer.md
Name: agc_loop_sequencer

Overview:
- Hardware closed-loop controller for one `agc_core` instance, running entirely in the aclk domain.
- Replaces the software tick/read/compute/load/apply loop: it sequences reset, integration, settling and evaluation, then the scale/offset load and apply strobes.
- The control law is a bang-bang stepper with saturation.
- Sits between the wishbone register block and `agc_core`; the register block only supplies configuration and reads back status.

Parameters:
- INTEG_CLOCKS, 131072: number of cycles `agc_ce_o` is held high per iteration.
- SETTLE_CLOCKS, 6: wait from end of integration until the accumulators are valid.
- SCALE_MIN, 17'h00100: lower saturation bound for scale.
- SCALE_MAX, 17'h1FFFF: upper saturation bound for scale.
- LOCK_COUNT, 4: consecutive unchanged iterations required to assert lock.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- enable_i  in  1  level; run the loop continuously while high.
- scale_init_i  in  17  scale loaded at start of run.
- offset_init_i  in  16  signed Q8.8 offset loaded at start of run.
- sq_target_lo_i  in  24  lower bound of the sq_accum window.
- sq_target_hi_i  in  24  upper bound of the sq_accum window.
- scale_step_i  in  8  unsigned scale increment.
- ofs_thresh_i  in  21  dead-band on (gt − lt).
- ofs_step_i  in  8  unsigned offset increment.
- sq_accum_i  in  24  from `agc_core`.
- gt_accum_i  in  21  from `agc_core`.
- lt_accum_i  in  21  from `agc_core`.
- agc_rst_o  out  1  accumulator/core reset pulse.
- agc_tick_o  out  1  integration start pulse.
- agc_ce_o  out  1  integration enable.
- agc_scale_o  out  17  current scale.
- agc_offset_o  out  16  current offset.
- agc_scale_ce_o  out  1  scale load strobe.
- agc_offset_ce_o  out  1  offset load strobe.
- agc_apply_o  out  1  apply strobe.
- iter_done_o  out  1  one pulse per completed iteration.
- iter_count_o  out  16  completed iterations since run start; wraps at 0xFFFF→0.
- locked_o  out  1  loop converged.

Behaviour:
- Reset (aresetn low): all strobes 0, `agc_ce_o` 0, scale/offset 0, `iter_count_o` 0, `locked_o` 0, state IDLE.
- States: IDLE, START, LOAD, APPLY, TICK, INTEG, SETTLE, EVAL.
- IDLE: outputs quiet. `enable_i` high → START.
- START (1 cycle): `agc_rst_o`=1; scale←scale_init_i, offset←offset_init_i; set the init flag; `iter_count_o`←0; `locked_o`←0 → LOAD.
- LOAD (1 cycle): `agc_scale_ce_o`=`agc_offset_ce_o`=1, driven with the registered scale/offset → APPLY.
- APPLY (1 cycle): `agc_apply_o`=1.
  - If the init flag is clear: `iter_done_o`=1 and `iter_count_o`+1.
  - Clear the init flag.
  - Next state: TICK if `enable_i`, else IDLE.
- TICK (1 cycle): `agc_tick_o`=1; counter←0 → INTEG.
- INTEG: `agc_ce_o`=1 for exactly INTEG_CLOCKS cycles (registered output, first high cycle is the first INTEG cycle) → SETTLE.
- SETTLE: SETTLE_CLOCKS cycles with `agc_ce_o`=0 → EVAL.
- EVAL (1 cycle): sample the accumulators and compute the new values.
  - Scale: if sq > hi, scale−step, saturated at SCALE_MIN; if sq < lo, scale+step, saturated at SCALE_MAX; else unchanged.
  - Offset: diff = gt − lt (22-bit signed). If diff > thresh, offset−step; if diff < −thresh, offset+step. Saturate to [−32768, 32767]; else unchanged.
  - Steps are zero-extended.
  - If both values are unchanged, the stable counter+1, saturating at LOCK_COUNT; else the stable counter←0.
  - `locked_o` = (stable counter == LOCK_COUNT).
  - Next state → LOAD; the strobes are issued even when values are unchanged.
- Comparison rules: compare the window bounds as unsigned. If lo > hi, treat the window as empty and force sq < lo to step up.
- `enable_i` low: in TICK/INTEG/SETTLE/EVAL → IDLE next cycle. `agc_ce_o` drops, no load/apply, `iter_done_o` not pulsed, scale/offset retained, `locked_o` cleared. LOAD→APPLY always completes.
- `enable_i` re-asserted in IDLE always passes through START, so values are re-initialised.
- Async reset mid-INTEG drops `agc_ce_o` immediately.
- The config inputs are sampled only in START/EVAL; they must be quasi-static.

Decomposition:
- Package `agc_seq_pkg` holds:
  - the state enum;
  - SCALE_W=17, OFFSET_W=16, SQ_W=24, CMP_W=21;
  - the Q8.8 offset saturation limits.
- One sub-module, `agc_step_sat`: the combinational EVAL law (scale/offset next value plus unchanged flags), to allow exhaustive unit test.
- Integration counter inline; a log2(INTEG_CLOCKS)+1 bit counter is sufficient.

Test Plan:
- INTEG_CLOCKS=16, SETTLE=6; enable high, scale_init=0x08000, offset_init=0 → rst at cycle 1 after enable, init load/apply without `iter_done_o`, tick, `agc_ce_o` high exactly 16 cycles, 6 settle cycles, load+apply, `iter_done_o`, `iter_count_o`=1.
- sq=0x200000 with window 0x100000–0x180000, step=0x40, scale 0x08000 → scale 0x07FC0 after iteration 1 and 0x07F80 after iteration 2. With scale_init=SCALE_MIN+0x10 it clamps at 0x00100.
- gt=1000, lt=100, thresh=50, ofs_step=8 → offset −8 (0xFFF8). gt=100, lt=1000 from offset 0x7FFC → saturates at 0x7FFF.
- sq in window, |gt−lt| ≤ thresh for 4 iterations → `locked_o` rises at the 4th EVAL; a subsequent out-of-window sample clears it at the next EVAL.
- enable dropped at INTEG cycle 5 → `agc_ce_o` low next cycle, no scale_ce/apply/iter_done pulses, state IDLE; re-enable → `agc_rst_o` and init reload.
- aresetn asserted mid-SETTLE → all outputs zero asynchronously; release with enable high → START sequence restarts cleanly.
